ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_pkg.sv | 34 +++
 rtl/bin2bcd_seq.sv | 62 ++++++
 rtl/ssd_scan_driver.sv | 91 +++++++++
 tb/tb_ssd_scan_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: segment encodings and BCD sizing helper shared by the scan driver
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0000100,
        7'b0000000,
        7'b0001111,
        7'b0100000,
        7'b0100100,
        7'b1001100,
        7'b0000110,
        7'b0010010,
        7'b1001111,
        7'b0000001
    };

    function automatic int bcd_digits(input int width);
        int r;
        int q;
        r = width * 3;
        q = 1;
        for (int i = 0; i < 8; i++) begin
            if (r >= 10) begin
                r = r - 10;
                q = q + 1;
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, one input bit per cycle, MSB first
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int BCD_DIGITS = bcd_digits(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        value,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]           shift_q, shift_d;
    logic [BCD_DIGITS-1:0][3:0] bcd_q, bcd_d;
    logic [4*BCD_DIGITS-1:0]    step;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       busy_q, busy_d;
    logic [3:0]                 d;
    logic                       c;

    // add-3 correct every digit, shift the next input bit in, and sequence WIDTH steps
    always_comb begin
        step = '0;
        d = '0;
        c = shift_q[WIDTH-1];
        for (int k = 0; k < BCD_DIGITS; k++) begin
            d = bcd_q[k] >= 4'd5 ? bcd_q[k] + 4'd3 : bcd_q[k];
            step[4*k +: 4] = {d[2:0], c};
            c = d[3];
        end
        done = busy_q && cnt_q == CW'(WIDTH - 1);
        busy_d = busy_q ? !done : start;
        shift_d = busy_q ? shift_q << 1 : start ? value : shift_q;
        bcd_d = busy_q ? step : start ? '0 : bcd_q;
        cnt_d = busy_q ? cnt_q + 1'b1 : '0;
    end

    // conversion state; reset abandons any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            shift_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            busy_q <= busy_d;
            shift_q <= shift_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign bcd = step;

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: binary-to-decimal multiplexed seven-segment display driver
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH = 16,
    parameter int REFRESH_BITS = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    input  logic              blank_lz,
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        ssd_out
);

    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic                       conv_done;
    logic [4*BCD_DIGITS-1:0]    conv_bcd;
    logic [BCD_DIGITS-1:0][3:0] disp_q, disp_d;
    logic [REFRESH_BITS-1:0]    pre_q, pre_d;
    logic [IW-1:0]              idx_q, idx_d, pos;
    logic [DIGITS-1:0]          anode_q, anode_d, lz;
    logic [6:0]                 seg_q, seg_d;
    logic [DIGITS-1:0][3:0]     dig;
    logic                       ovf, zero, blank;

    bin2bcd_seq #(.WIDTH(WIDTH)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .value (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        if (g < BCD_DIGITS) begin : g_src
            assign dig[g] = disp_q[g];
        end else begin : g_pad
            assign dig[g] = 4'd0;
        end
    end

    // scan sequencing, leading-zero detection, and segment/anode selection
    always_comb begin
        ovf = 1'b0;
        for (int k = 0; k < BCD_DIGITS; k++) ovf = ovf | (k >= DIGITS && disp_q[k] != 4'd0);
        zero = 1'b1;
        lz = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero = zero && dig[k] == 4'd0;
            lz[k] = zero;
        end
        pos = IW'(DIGITS - 1) - idx_q;
        blank = blank_lz && !ovf && pos != '0 && lz[pos];
        pre_d = pre_q + 1'b1;
        idx_d = !(&pre_q) ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
        disp_d = conv_done ? conv_bcd : disp_q;
        anode_d = ~(DIGITS'(1) << pos);
        seg_d = ovf ? SEG_DASH : blank ? SEG_BLANK : SEG_DIGIT[dig[pos]];
    end

    // display register swaps only when a conversion completes; outputs lag the scan by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= '0;
            pre_q <= '0;
            idx_q <= '0;
            anode_q <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            disp_q <= disp_d;
            pre_q <= pre_d;
            idx_q <= idx_d;
            anode_q <= anode_d;
            seg_q <= seg_d;
        end
    end

    assign overflow = ovf;
    assign anode = anode_q;
    assign ssd_out = seg_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: scoreboard bench for the seven-segment scan driver
module tb_ssd_scan_driver;

    typedef struct packed {
        logic [0:7][6:0] seg;
        logic            ovf;
        logic [7:0]      len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, load4, load6, blank_lz, sel;
    logic [15:0] value4;
    logic [19:0] value6;
    logic        busy4, busy6, ovf4, ovf6;
    logic [3:0]  anode4;
    logic [5:0]  anode6;
    logic [6:0]  seg4, seg6;
    logic        m_busy, m_ovf;
    logic [7:0]  m_anode;
    logic [6:0]  m_seg;
    int          nd;
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          capturing = 1'b0;

    always #5 clk = ~clk;

    ssd_scan_driver #(.DIGITS(4), .WIDTH(16), .REFRESH_BITS(2)) u_dut4 (
        .clk(clk), .rst(rst), .value(value4), .load(load4), .blank_lz(blank_lz),
        .busy(busy4), .overflow(ovf4), .anode(anode4), .ssd_out(seg4)
    );

    ssd_scan_driver #(.DIGITS(6), .WIDTH(20), .REFRESH_BITS(2)) u_dut6 (
        .clk(clk), .rst(rst), .value(value6), .load(load6), .blank_lz(blank_lz),
        .busy(busy6), .overflow(ovf6), .anode(anode6), .ssd_out(seg6)
    );

    assign m_busy  = sel ? busy6 : busy4;
    assign m_ovf   = sel ? ovf6 : ovf4;
    assign m_anode = sel ? {2'b11, anode6} : {4'hF, anode4};
    assign m_seg   = sel ? seg6 : seg4;
    assign nd      = sel ? 6 : 4;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    task automatic expect_frame(input logic [0:7][6:0] segs, input logic ovf, input int len);
        exp_t e;
        e.seg = segs;
        e.ovf = ovf;
        e.len = len[7:0];
        exp_q.push_back(e);
    endtask

    task automatic do_load(input bit s, input logic [19:0] v, input bit blz,
                           input logic [0:7][6:0] segs, input logic ovf, input int len);
        sel = s;
        blank_lz = blz;
        expect_frame(segs, ovf, len);
        @(negedge clk);
        if (s) begin
            value6 = v;
            load6 = 1'b1;
        end else begin
            value4 = v[15:0];
            load4 = 1'b1;
        end
        @(negedge clk);
        load4 = 1'b0;
        load6 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || capturing) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || capturing) begin
            n_checks++;
            $display("FAIL drain_timeout got=%0d cycles exp=<300", t);
        end
    endtask

    // monitor: on every busy fall, pop the expected frame and compare a full scan
    initial begin : monitor
        int busy_cnt;
        int bad;
        bit found;
        int cnt [8];
        exp_t e;
        logic [0:7][6:0] got;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (m_busy) busy_cnt++;
            else if (busy_cnt != 0) begin
                if (exp_q.size() == 0) chk("unexpected_done", busy_cnt, 0);
                else begin
                    e = exp_q.pop_front();
                    capturing = 1'b1;
                    chk("busy_len", busy_cnt, e.len);
                    chk("overflow", m_ovf, e.ovf);
                    got = '1;
                    bad = 0;
                    for (int p = 0; p < 8; p++) cnt[p] = 0;
                    for (int c = 0; c < nd * 4 + 2; c++) begin
                        @(negedge clk);
                        found = 1'b0;
                        for (int p = 0; p < nd; p++) begin
                            if (m_anode == (8'hFF & ~(8'd1 << (nd - 1 - p)))) begin
                                found = 1'b1;
                                got[p] = m_seg;
                                if (c < nd * 4) cnt[p]++;
                            end
                        end
                        if (!found) bad++;
                    end
                    chk("anode_invalid_samples", bad, 0);
                    for (int p = 0; p < nd; p++) begin
                        chk($sformatf("seg_pos%0d", p), got[p], e.seg[p]);
                        chk($sformatf("dwell_pos%0d", p), cnt[p], 4);
                    end
                    capturing = 1'b0;
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        load4 = 1'b0;
        load6 = 1'b0;
        value4 = '0;
        value6 = '0;
        blank_lz = 1'b1;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy4", busy4, 0);
        chk("rst_ovf4", ovf4, 0);
        chk("rst_anode4", anode4, 4'hF);
        chk("rst_seg4", seg4, 7'h7F);
        chk("rst_busy6", busy6, 0);
        chk("rst_anode6", anode6, 6'h3F);
        chk("rst_seg6", seg6, 7'h7F);
        rst = 1'b0;
        @(negedge clk);
        chk("first_anode4", anode4, 4'b0111);
        chk("first_seg4", seg4, 7'h7F);
        chk("first_anode6", anode6, 6'b011111);
        chk("first_seg6", seg6, 7'h7F);

        do_load(0, 1234, 0, {7'h4F, 7'h12, 7'h06, 7'h4C, 28'd0}, 0, 16);
        drain();
        do_load(0, 7, 1, {7'h7F, 7'h7F, 7'h7F, 7'h0F, 28'd0}, 0, 16);
        drain();
        do_load(0, 7, 0, {7'h01, 7'h01, 7'h01, 7'h0F, 28'd0}, 0, 16);
        drain();
        do_load(0, 65535, 1, {{4{7'h7E}}, 28'd0}, 1, 16);
        drain();
        do_load(0, 0, 0, {{4{7'h01}}, 28'd0}, 0, 16);
        drain();
        do_load(0, 0, 1, {7'h7F, 7'h7F, 7'h7F, 7'h01, 28'd0}, 0, 16);
        drain();
        do_load(0, 1005, 1, {7'h4F, 7'h01, 7'h01, 7'h24, 28'd0}, 0, 16);
        drain();
        do_load(0, 9999, 0, {{4{7'h04}}, 28'd0}, 0, 16);
        drain();
        do_load(0, 10000, 0, {{4{7'h7E}}, 28'd0}, 1, 16);
        drain();

        sel = 1'b0;
        blank_lz = 1'b0;
        expect_frame({7'h01, 7'h01, 7'h4C, 7'h12, 28'd0}, 0, 16);
        @(negedge clk);
        value4 = 42;
        load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
        repeat (4) @(negedge clk);
        value4 = 99;
        load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
        drain();

        expect_frame({{4{7'h01}}, 28'd0}, 0, 8);
        @(negedge clk);
        value4 = 9999;
        load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy4, 0);
        chk("abort_ovf", ovf4, 0);
        chk("abort_anode", anode4, 4'hF);
        chk("abort_seg", seg4, 7'h7F);
        rst = 1'b0;
        drain();

        do_load(1, 999999, 0, {{6{7'h04}}, 14'd0}, 0, 20);
        drain();
        do_load(1, 1000000, 1, {{6{7'h7E}}, 14'd0}, 1, 20);
        drain();
        do_load(1, 120, 1, {7'h7F, 7'h7F, 7'h7F, 7'h4F, 7'h12, 7'h01, 14'd0}, 0, 20);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
